// File: rtl/mux_vector_sequencer_if.sv
// Signal bundle between the vector sequencer and the mux-under-test environment.
// The sequencer holds the master modport; the environment (mux plus start source) holds the slave.
interface mux_vector_sequencer_if #(
  parameter int unsigned ERR_W = 4
) ();

  logic             start;
  logic             z_in;
  logic             a_out;
  logic             b_out;
  logic             c_out;
  logic [2:0]       vec_idx;
  logic             busy;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [2:0]       fail_vec;
  logic             pass;
  logic             done;

  modport master (
    input  start,
    input  z_in,
    output a_out,
    output b_out,
    output c_out,
    output vec_idx,
    output busy,
    output mismatch,
    output err_count,
    output fail_valid,
    output fail_vec,
    output pass,
    output done
  );

  modport slave (
    output start,
    output z_in,
    input  a_out,
    input  b_out,
    input  c_out,
    input  vec_idx,
    input  busy,
    input  mismatch,
    input  err_count,
    input  fail_valid,
    input  fail_vec,
    input  pass,
    input  done
  );

endinterface

// File: rtl/mux_vector_sequencer.sv
// Sweeps all eight {a,b,c} vectors into a 2:1 select mux, waits a settle window,
// then checks z against b ? c : a. Keeps an error count, the first failing vector
// and a pass flag. Every output comes straight from a flop.
module mux_vector_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_vector_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  localparam logic [3:0]       SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ErrMax     = '1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       abc_q, abc_d;
  logic             busy_q, busy_d;
  logic             mm_q, mm_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [2:0]       fvec_q, fvec_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;

  logic golden;
  logic miss;

  // Golden mux value for the vector currently applied; X/Z on z_in counts as a miss.
  always_comb begin
    golden = idx_q[1] ? idx_q[0] : idx_q[2];
    miss   = (bus.z_in !== golden);
  end

  // Next-state and next-output logic; outputs are derived from the next state so they register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    pass_d  = pass_q;
    mm_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = 3'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = 4'd0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (miss) begin
          mm_d = 1'b1;
          if (err_q != ErrMax) err_d = err_q + ERR_W'(1);
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = idx_q;
          end
        end
        if (idx_q == 3'd7) begin
          // err_q does not yet include this sample, so fold the final miss in directly.
          pass_d  = (err_q == '0) && !miss;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StDrive) || (state_d == StSample);
    abc_d  = busy_d ? idx_d : 3'd0;
    done_d = (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      mm_q    <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= 3'd0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      mm_q    <= mm_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign bus.a_out      = abc_q[2];
  assign bus.b_out      = abc_q[1];
  assign bus.c_out      = abc_q[0];
  assign bus.vec_idx    = idx_q;
  assign bus.busy       = busy_q;
  assign bus.mismatch   = mm_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;
  assign bus.pass       = pass_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mux_vector_sequencer.sv
// Bench for mux_vector_sequencer: three instances (default, ERR_W=2, SETTLE_CYCLES=1),
// each fed by a selectable mux model (correct, tied low, inverted).
module tb_mux_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] start_v;
  logic [1:0] mode_v [3];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [2:0] abc;
    logic [2:0] idx;
    logic       busy;
    logic       mm;
    logic [7:0] err;
    logic       fv;
    logic [2:0] fvec;
    logic       pass;
    logic       done;
  } obs_t;

  typedef struct {
    int         sel;
    logic [1:0] mode;
    int         done_cyc;
    int         err;
    logic       fv;
    logic [2:0] fvec;
    logic       pass;
    logic [7:0] mask;
    logic       poke;
  } row_t;

  // Mux seen by the sequencer: 0 correct, 1 stuck at 0, 2 inverted.
  function automatic logic zfun(input logic [1:0] mode, input logic a, input logic b,
                                input logic c);
    logic m;
    m = (a & ~b) | (c & b);
    case (mode)
      2'd1:    return 1'b0;
      2'd2:    return ~m;
      default: return m;
    endcase
  endfunction

  mux_vector_sequencer_if #(.ERR_W(4)) bus0 ();
  mux_vector_sequencer_if #(.ERR_W(2)) bus1 ();
  mux_vector_sequencer_if #(.ERR_W(4)) bus2 ();

  mux_vector_sequencer #(.SETTLE_CYCLES(2), .ERR_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_vector_sequencer #(.SETTLE_CYCLES(2), .ERR_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_vector_sequencer #(.SETTLE_CYCLES(1), .ERR_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.start = start_v[0];
  assign bus1.start = start_v[1];
  assign bus2.start = start_v[2];
  assign bus0.z_in  = zfun(mode_v[0], bus0.a_out, bus0.b_out, bus0.c_out);
  assign bus1.z_in  = zfun(mode_v[1], bus1.a_out, bus1.b_out, bus1.c_out);
  assign bus2.z_in  = zfun(mode_v[2], bus2.a_out, bus2.b_out, bus2.c_out);

  obs_t obs0, obs1, obs2;
  assign obs0 = {bus0.a_out, bus0.b_out, bus0.c_out, bus0.vec_idx, bus0.busy, bus0.mismatch,
                 8'(bus0.err_count), bus0.fail_valid, bus0.fail_vec, bus0.pass, bus0.done};
  assign obs1 = {bus1.a_out, bus1.b_out, bus1.c_out, bus1.vec_idx, bus1.busy, bus1.mismatch,
                 8'(bus1.err_count), bus1.fail_valid, bus1.fail_vec, bus1.pass, bus1.done};
  assign obs2 = {bus2.a_out, bus2.b_out, bus2.c_out, bus2.vec_idx, bus2.busy, bus2.mismatch,
                 8'(bus2.err_count), bus2.fail_valid, bus2.fail_vec, bus2.pass, bus2.done};

  function automatic obs_t get_obs(input int sel);
    case (sel)
      1:       return obs1;
      2:       return obs2;
      default: return obs0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // One full sweep on instance r.sel, optionally poking start mid-sweep and during DONE.
  task automatic run_sweep(input row_t r);
    obs_t       o;
    int         n;
    logic [7:0] mask;
    logic [2:0] prev;
    bit         drive_ok, got_done, poked;
    mode_v[r.sel] = r.mode;
    @(negedge clk);
    start_v[r.sel] = 1'b1;
    @(posedge clk);
    #1;
    start_v[r.sel] = 1'b0;
    o = get_obs(r.sel);
    check("clear_on_start", int'({o.busy, o.fv, o.pass, o.err}), int'({1'b1, 1'b0, 1'b0, 8'd0}));
    n = 1; mask = '0; prev = '0; drive_ok = 1'b1; got_done = 1'b0; poked = 1'b0;
    while (n < 200) begin
      if (o.busy && (o.abc !== o.idx)) drive_ok = 1'b0;
      if (o.mm) mask[prev] = 1'b1;
      if (o.done) begin
        got_done = 1'b1;
        break;
      end
      prev = o.idx;
      if (r.poke && (o.idx == 3'd2) && !poked) begin
        start_v[r.sel] = 1'b1;
        poked = 1'b1;
      end
      @(posedge clk);
      #1;
      start_v[r.sel] = 1'b0;
      n++;
      o = get_obs(r.sel);
    end
    check("done_seen", int'(got_done), 1);
    check("done_cycle", n, r.done_cyc);
    check("drive_matches_idx", int'(drive_ok), 1);
    check("mismatch_mask", int'(mask), int'(r.mask));
    check("abc_zero_in_done", int'(o.abc), 0);
    check("err_at_done", int'(o.err), r.err);
    if (r.poke) start_v[r.sel] = 1'b1;
    @(posedge clk);
    #1;
    start_v[r.sel] = 1'b0;
    o = get_obs(r.sel);
    check("idle_state", int'({o.busy, o.abc, o.idx, o.done}), int'({1'b0, 3'd0, 3'd7, 1'b0}));
    check("err_count", int'(o.err), r.err);
    check("fail_valid", int'(o.fv), int'(r.fv));
    if (r.fv) check("fail_vec", int'(o.fvec), int'(r.fvec));
    check("pass", int'(o.pass), int'(r.pass));
    @(posedge clk);
    #1;
    o = get_obs(r.sel);
    check("no_restart", int'({o.busy, o.pass}), int'({1'b0, r.pass}));
  endtask

  row_t rows [7];

  initial begin
    obs_t o;
    int   n;
    row_t clean;

    rows[0] = '{0, 2'd0, 25, 0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};
    rows[1] = '{0, 2'd1, 25, 4, 1'b1, 3'd3, 1'b0, 8'hB8, 1'b0};
    rows[2] = '{0, 2'd2, 25, 8, 1'b1, 3'd0, 1'b0, 8'hFF, 1'b0};
    rows[3] = '{1, 2'd2, 25, 3, 1'b1, 3'd0, 1'b0, 8'hFF, 1'b0};
    rows[4] = '{0, 2'd0, 25, 0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1};
    rows[5] = '{2, 2'd1, 17, 4, 1'b1, 3'd3, 1'b0, 8'hB8, 1'b0};
    rows[6] = '{2, 2'd0, 17, 0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0};
    clean   = rows[0];

    start_v = '0;
    for (int i = 0; i < 3; i++) mode_v[i] = 2'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check("reset_outputs", int'(get_obs(i)), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_sweep(rows[i]);

    // Asynchronous reset while vector 4 is being driven.
    mode_v[0] = 2'd1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    n = 0;
    o = get_obs(0);
    while (o.idx != 3'd4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      o = get_obs(0);
    end
    check("reach_idx4", int'({o.busy, o.idx}), int'({1'b1, 3'd4}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(get_obs(0)), 0);
    @(posedge clk);
    #1;
    check("reset_held_outputs", int'(get_obs(0)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(clean);

    // start held high re-triggers from the IDLE cycle after DONE.
    mode_v[0] = 2'd0;
    @(negedge clk);
    start_v[0] = 1'b1;
    n = 0;
    o = get_obs(0);
    while (!o.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      o = get_obs(0);
    end
    check("held_done_cycle", n, 25);
    @(posedge clk);
    #1;
    o = get_obs(0);
    check("held_idle_gap", int'({o.busy, o.pass}), int'({1'b0, 1'b1}));
    @(posedge clk);
    #1;
    o = get_obs(0);
    check("held_restart", int'({o.busy, o.idx, o.pass}), int'({1'b1, 3'd0, 1'b0}));
    start_v[0] = 1'b0;
    n = 0;
    while (!o.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      o = get_obs(0);
    end
    check("held_second_done", n, 24);
    @(posedge clk);
    #1;
    o = get_obs(0);
    check("held_second_pass", int'({o.pass, o.err}), int'({1'b1, 8'd0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
